// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle from vga_sync_gen to the pixel generator and connector.
interface vga_sync_gen_if;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       p_tick;
    logic       frame_start;

    modport master (
        output pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );

    modport slave (
        input pixel_x, pixel_y, video_on, hsync, vsync, p_tick, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing master: pixel-rate tick, x/y counters, registered video_on/hsync/vsync/frame_start.
// Optional VGA_SYNC_ALIGN_EN delays hsync/vsync by one clk to line up with a registered rgb_out.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_sync_gen_if.master vga
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);
    localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
    localparam logic       SYNC_ACT   = (SYNC_POL != 0);

    logic [3:0] div;
    logic       p_tick;
    logic [9:0] pixel_x, pixel_y;
    logic [9:0] x_nxt, y_nxt;
    logic       frame_wrap;
    logic       video_on, hsync_raw, vsync_raw, frame_start;

    assign p_tick = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div <= '0;
        end else if (p_tick) begin
            div <= '0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_comb begin
        x_nxt      = pixel_x;
        y_nxt      = pixel_y;
        frame_wrap = 1'b0;
        if (p_tick) begin
            if (pixel_x == H_LAST) begin
                x_nxt = '0;
                if (pixel_y == V_LAST) begin
                    y_nxt      = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_nxt = pixel_y + 10'd1;
                end
            end else begin
                x_nxt = pixel_x + 10'd1;
            end
        end
    end

    // Decodes are taken from the next-state counters so they register in lockstep with pixel_x/pixel_y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            hsync_raw   <= ~SYNC_ACT;
            vsync_raw   <= ~SYNC_ACT;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= x_nxt;
            pixel_y     <= y_nxt;
            video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync_raw   <= ((x_nxt >= HS_START) && (x_nxt < HS_END)) ? SYNC_ACT : ~SYNC_ACT;
            vsync_raw   <= ((y_nxt >= VS_START) && (y_nxt < VS_END)) ? SYNC_ACT : ~SYNC_ACT;
            frame_start <= frame_wrap;
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_dly, vsync_dly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_dly <= ~SYNC_ACT;
            vsync_dly <= ~SYNC_ACT;
        end else begin
            hsync_dly <= hsync_raw;
            vsync_dly <= vsync_raw;
        end
    end

    assign vga.hsync = hsync_dly;
    assign vga.vsync = vsync_dly;
`else
    assign vga.hsync = hsync_raw;
    assign vga.vsync = vsync_raw;
`endif

    assign vga.pixel_x     = pixel_x;
    assign vga.pixel_y     = pixel_y;
    assign vga.video_on    = video_on;
    assign vga.p_tick      = p_tick;
    assign vga.frame_start = frame_start;
endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: full 800-pixel lines, shortened 13-line frame to keep runtime short.
module tb_vga_sync_gen;
`ifdef VGA_SYNC_ALIGN_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   edge_cnt;
    int   fs_count;

    vga_sync_gen_if vif ();

    vga_sync_gen #(
        .CLK_DIV   (2),
        .H_DISPLAY (640),
        .H_FRONT   (16),
        .H_SYNC    (96),
        .H_BACK    (48),
        .V_DISPLAY (6),
        .V_FRONT   (2),
        .V_SYNC    (2),
        .V_BACK    (3),
        .SYNC_POL  (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    // Step clock edges since reset release until edge_cnt==target; sample on the falling edge.
    task automatic run_to(input int target);
        while (edge_cnt < target) begin
            @(posedge clk);
            edge_cnt++;
            @(negedge clk);
            if (vif.frame_start) fs_count++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        edge_cnt = 0;
        fs_count = 0;
        rst_n    = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_x", vif.pixel_x, 0);
        check("rst_y", vif.pixel_y, 0);
        check("rst_video", vif.video_on, 0);
        check("rst_hsync", vif.hsync, 1);
        check("rst_vsync", vif.vsync, 1);
        check("rst_fs", vif.frame_start, 0);

        rst_n = 1'b1;
        run_to(1);
        check("e1_x", vif.pixel_x, 0);
        check("e1_video", vif.video_on, 1);
        check("e1_ptick", vif.p_tick, 1);
        check("e1_hsync", vif.hsync, 1);
        check("e1_fs", vif.frame_start, 0);
        run_to(2);
        check("e2_x", vif.pixel_x, 1);
        check("e2_ptick", vif.p_tick, 0);
        run_to(3);
        check("e3_x", vif.pixel_x, 1);
        check("e3_ptick", vif.p_tick, 1);

        run_to(1278);
        check("x639", vif.pixel_x, 639);
        check("x639_video", vif.video_on, 1);
        run_to(1280);
        check("x640", vif.pixel_x, 640);
        check("x640_video", vif.video_on, 0);

        run_to(1311 + SK);
        check("hs_pre_fall", vif.hsync, 1);
        run_to(1312);
        check("x656", vif.pixel_x, 656);
        check("hs_at_656", vif.hsync, (SK == 1) ? 1 : 0);
        run_to(1313);
        check("hs_low", vif.hsync, 0);
        run_to(1503 + SK);
        check("hs_pre_rise", vif.hsync, 0);
        run_to(1504 + SK);
        check("x752", vif.pixel_x, 752);
        check("hs_rise", vif.hsync, 1);

        run_to(1599);
        check("x799", vif.pixel_x, 799);
        check("x799_y", vif.pixel_y, 0);
        run_to(1600);
        check("wrap_x", vif.pixel_x, 0);
        check("wrap_y", vif.pixel_y, 1);
        check("wrap_video", vif.video_on, 1);

        run_to(8000);
        check("y5_video", vif.video_on, 1);
        run_to(9600);
        check("y6", vif.pixel_y, 6);
        check("y6_video", vif.video_on, 0);

        run_to(12799 + SK);
        check("vs_pre_fall", vif.vsync, 1);
        run_to(12800 + SK);
        check("vs_fall", vif.vsync, 0);
        run_to(15999 + SK);
        check("vs_pre_rise", vif.vsync, 0);
        run_to(16000 + SK);
        check("vs_rise", vif.vsync, 1);

        run_to(20799);
        check("last_x", vif.pixel_x, 799);
        check("last_y", vif.pixel_y, 12);
        check("fs_before", vif.frame_start, 0);
        run_to(20800);
        check("fs_pulse", vif.frame_start, 1);
        check("fs_x", vif.pixel_x, 0);
        check("fs_y", vif.pixel_y, 0);
        run_to(20801);
        check("fs_after", vif.frame_start, 0);
        check("fs_count1", fs_count, 1);
        run_to(41600);
        check("fs_pulse2", vif.frame_start, 1);
        run_to(41601);
        check("fs_count2", fs_count, 2);

        run_to(47800);
        check("mid_x", vif.pixel_x, 700);
        check("mid_y", vif.pixel_y, 3);
        check("mid_hsync", vif.hsync, 0);
        rst_n = 1'b0;
        #1;
        check("arst_x", vif.pixel_x, 0);
        check("arst_y", vif.pixel_y, 0);
        check("arst_video", vif.video_on, 0);
        check("arst_hsync", vif.hsync, 1);
        @(negedge clk);
        rst_n    = 1'b1;
        edge_cnt = 0;
        run_to(1);
        check("re_x", vif.pixel_x, 0);
        check("re_y", vif.pixel_y, 0);
        check("re_video", vif.video_on, 1);
        check("re_hsync", vif.hsync, 1);
        run_to(2);
        check("re_x1", vif.pixel_x, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
